acq_capture: RTL and testbench
==============================

Name: acq_capture

Overview:
- Sink for the receive-path filter output: takes the 4-sample-per-clock I/Q stream (`data_out_i`/`data_out_q` with `filter_valid`) while the ADC window (`ADC_enable`) is open.
- Buffers the samples and writes them as addressed 128-bit words into memory bank #2 over a valid/ready write port.
- Absorbs memory back-pressure with an internal FIFO, since the filter stream cannot stall.
- Sits between the operations block and the memory bank #2 controller; software arms it once per scan.

Parameters:
- ADDR_W, 14, width of the bank #2 word address and sample counter.
- FIFO_DEPTH, 16, FIFO depth in 128-bit words; must be a power of two, minimum 4.
- LANE_W, 16, bits per I or Q sample; 4 lanes per word.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- arm  in  1  single-cycle start pulse; honoured only in IDLE.
- num_words  in  ADDR_W  words to capture per acquisition; sampled on accepted arm.
- ADC_enable  in  1  acquisition window from the pulsers.
- filter_valid  in  1  qualifier for data_in_i/q.
- data_in_i  in  4*LANE_W  in-phase samples, lane 0 in LSBs.
- data_in_q  in  4*LANE_W  quadrature samples.
- mem_wr_data  out  8*LANE_W  {I word, Q word}; I in [127:64].
- mem_wr_addr  out  ADDR_W  word address, 0-based per acquisition.
- mem_wr_valid  out  1  write request.
- mem_wr_ready  in  1  memory accepts when valid && ready.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at end of acquisition.
- overflow  out  1  sticky; a word was dropped on FIFO full; cleared on accepted arm.

Behaviour:
- Reset: all outputs 0, FIFO emptied, state IDLE. Reset mid-acquisition aborts with no done pulse.
- States:
  - IDLE: arm → CAPTURE. Latches num_words, clears word counter and overflow. If num_words == 0, go directly to DONE.
  - CAPTURE: a word is accepted on any cycle with ADC_enable && filter_valid. Each accepted word is tagged addr = word counter, then the counter increments.
  - CAPTURE → DRAIN when either:
    - the counter reaches num_words (same cycle as the last accepted word), or
    - ADC_enable falls after at least one word has been accepted (early end).
  - ADC_enable low before the first accepted word keeps the block waiting in CAPTURE.
  - DRAIN: no new words accepted. → DONE when the FIFO is empty and no write is outstanding.
  - DONE: done = 1 for one cycle, busy = 1, then → IDLE. arm in DONE is ignored.
- Latency: a word accepted at cycle t is registered at t+1 and enqueued into a show-ahead FIFO; mem_wr_valid asserts at t+2 at the earliest.
- Handshake:
  - mem_wr_valid, once high, stays high with mem_wr_data/addr stable until mem_wr_ready.
  - Writes are issued in address order.
  - Back-to-back transfers at one per cycle are supported.
- FIFO full on enqueue:
  - The word is dropped and overflow set.
  - The counter still increments, so later addresses stay time-aligned and the dropped address is never written.
  - Enqueue and dequeue in the same cycle at full is not a drop.
- Counter wrap: num_words is limited to 2^ADDR_W-1, so the counter never wraps within an acquisition.
- arm while busy is ignored and has no side effects.

Optional Feature:
- Macro: ACQ_CAPTURE_DECIM_EN.
- When defined:
  - Adds input port decim (4 bits), sampled on arm.
  - Only every (decim+1)-th gated word is accepted; gated words are those with ADC_enable && filter_valid. decim = 0 keeps every word.
  - The phase counter resets on arm.
  - num_words counts accepted (post-decimation) words.
- When undefined: the port is absent and every gated word is accepted.

Decomposition:
- Package acq_pkg:
  - state enum (IDLE, CAPTURE, DRAIN, DONE);
  - lane count constant 4;
  - word width 8*LANE_W;
  - FIFO entry layout {addr, data}.
- Sub-module capture_fifo:
  - synchronous show-ahead FIFO;
  - width ADDR_W+8*LANE_W, depth FIFO_DEPTH;
  - full/empty flags;
  - async active-low reset.

Test Plan:
- Basic capture: arm with num_words = 8, ADC_enable high, filter_valid every cycle, mem_wr_ready = 1 → 8 writes at addr 0..7 with data matching inputs; done pulse once; overflow = 0.
- Back-pressure: num_words = 40, FIFO_DEPTH = 16, mem_wr_ready held low for 20 cycles then high → overflow = 1. Expect a drop at each gated word that arrives with the FIFO full; those addresses are missing, and all other addresses are written in order with correct data.
- Early end: num_words = 100, ADC_enable falls after 10 gated words → 10 writes (addr 0..9), then done; busy low the cycle after done.
- Zero length: arm with num_words = 0 → no mem_wr_valid, done on the cycle after arm.
- Ignored arm and reset abort: arm pulsed mid-CAPTURE → no effect. Then rst_n low for 1 cycle mid-DRAIN → all outputs 0 immediately, no done, and a new arm starts cleanly.
- Decimation (ACQ_CAPTURE_DECIM_EN): decim = 2, num_words = 4, 12 consecutive gated words → input words 0, 3, 6, 9 written at addr 0..3.

Source files
------------

// File: rtl/acq_pkg.sv
// acq_pkg: shared state type and sizing helpers for the capture path.
// Optional decimation is enabled by defining ACQ_CAPTURE_DECIM_EN.
package acq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN,
    DONE
  } state_t;

  localparam int LANES = 4;

  function automatic int word_w(input int lane_w);
    return 2 * LANES * lane_w;
  endfunction

  // FIFO entries pack as {addr, data}
  function automatic int entry_w(input int addr_w,
                                 input int lane_w);
    return addr_w + word_w(lane_w);
  endfunction

endpackage

// File: rtl/acq_capture_if.sv
// acq_capture_if: bank #2 write port, valid/ready handshake.
// Shared by acq_capture (master) and the memory controller (slave).
interface acq_capture_if
  import acq_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int LANE_W = 16
);

  logic [word_w(LANE_W)-1:0] mem_wr_data;
  logic [ADDR_W-1:0]         mem_wr_addr;
  logic                      mem_wr_valid;
  logic                      mem_wr_ready;

  modport master (
    output mem_wr_data,
    output mem_wr_addr,
    output mem_wr_valid,
    input  mem_wr_ready
  );

  modport slave (
    input  mem_wr_data,
    input  mem_wr_addr,
    input  mem_wr_valid,
    output mem_wr_ready
  );

endinterface

// File: rtl/capture_fifo.sv
// capture_fifo: synchronous show-ahead FIFO, head visible when !empty.
// A push at full is taken only if a pop happens in the same cycle.
module capture_fifo #(
  parameter int W     = 142,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q, wptr_d;
  logic [AW:0]  rptr_q, rptr_d;
  logic         wr_en, rd_en;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign rdata = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_en) wptr_d = wptr_q + 1'b1;
    if (rd_en) rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/acq_capture.sv
// acq_capture: filter I/Q sink writing 128-bit words to bank #2.
// Define ACQ_CAPTURE_DECIM_EN to add the decim input (keep 1 in decim+1).
module acq_capture
  import acq_pkg::*;
#(
  parameter int ADDR_W     = 14,
  parameter int FIFO_DEPTH = 16,
  parameter int LANE_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    arm,
  input  logic [ADDR_W-1:0]       num_words,
`ifdef ACQ_CAPTURE_DECIM_EN
  input  logic [3:0]              decim,
`endif
  input  logic                    ADC_enable,
  input  logic                    filter_valid,
  input  logic [LANES*LANE_W-1:0] data_in_i,
  input  logic [LANES*LANE_W-1:0] data_in_q,
  acq_capture_if.master           mem,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow
);

  localparam int WW = word_w(LANE_W);
  localparam int EW = entry_w(ADDR_W, LANE_W);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] num_q, num_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              s1_vld_q, s1_vld_d;
  logic [EW-1:0]     s1_q, s1_d;
  logic [EW-1:0]     head;
  logic              start, gated, accept, last;
  logic              full, empty, pop, drop, wr_vld;

  assign start = (state_q == IDLE) && arm;
  assign gated = (state_q == CAPTURE) && ADC_enable && filter_valid;
  assign last  = (cnt_q + 1'b1) == num_q;

`ifdef ACQ_CAPTURE_DECIM_EN
  logic [3:0] dec_q, dec_d;
  logic [3:0] ph_q, ph_d;

  assign accept = gated && (ph_q == '0);

  always_comb begin
    dec_d = dec_q;
    ph_d  = ph_q;
    if (gated) ph_d = (ph_q == dec_q) ? '0 : ph_q + 1'b1;
    if (start) begin
      dec_d = decim;
      ph_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_q <= '0;
      ph_q  <= '0;
    end else begin
      dec_q <= dec_d;
      ph_q  <= ph_d;
    end
  end
`else
  assign accept = gated;
`endif

  // Full without a same-cycle pop loses the word; its address is skipped
  assign wr_vld = !empty;
  assign pop    = wr_vld && mem.mem_wr_ready;
  assign drop   = s1_vld_q && full && !pop;

  always_comb begin
    num_d    = num_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    s1_vld_d = accept;
    s1_d     = s1_q;
    if (accept) begin
      s1_d  = {cnt_q, data_in_i, data_in_q};
      cnt_d = cnt_q + 1'b1;
    end
    if (drop) ovf_d = 1'b1;
    if (start) begin
      num_d = num_words;
      cnt_d = '0;
      ovf_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (arm) state_d = (num_words == '0) ? DONE : CAPTURE;
      end
      CAPTURE: begin
        if (accept && last) state_d = DRAIN;
        else if (!ADC_enable && cnt_q != '0) state_d = DRAIN;
      end
      DRAIN: begin
        if (empty && !s1_vld_q) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      num_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      s1_vld_q <= 1'b0;
      s1_q     <= '0;
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      s1_vld_q <= s1_vld_d;
      s1_q     <= s1_d;
    end
  end

  capture_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (s1_vld_q),
    .pop   (pop),
    .wdata (s1_q),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign mem.mem_wr_valid = wr_vld;
  assign mem.mem_wr_addr  = wr_vld ? head[EW-1:WW] : '0;
  assign mem.mem_wr_data  = wr_vld ? head[WW-1:0] : '0;

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_acq_capture.sv
// tb_acq_capture: directed scenarios with an address/data scoreboard.
// Build with +define+ACQ_CAPTURE_DECIM_EN to include the decimation case.
module tb_acq_capture;
  import acq_pkg::*;

  localparam int AW    = 14;
  localparam int LW    = 16;
  localparam int DEPTH = 16;

  typedef struct {
    logic [AW-1:0] addr;
    logic [127:0]  data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          arm = 1'b0;
  logic [AW-1:0] num = '0;
  logic          adc = 1'b0;
  logic          fv = 1'b0;
  logic [63:0]   di = '0;
  logic [63:0]   dq = '0;
  logic          busy, done, overflow;
`ifdef ACQ_CAPTURE_DECIM_EN
  logic [3:0]    decim = '0;
`endif

  acq_capture_if #(.ADDR_W(AW), .LANE_W(LW)) mem ();

  acq_capture #(
    .ADDR_W     (AW),
    .FIFO_DEPTH (DEPTH),
    .LANE_W     (LW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .arm          (arm),
    .num_words    (num),
`ifdef ACQ_CAPTURE_DECIM_EN
    .decim        (decim),
`endif
    .ADC_enable   (adc),
    .filter_valid (fv),
    .data_in_i    (di),
    .data_in_q    (dq),
    .mem          (mem),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_wr, n_skip, n_done, first_skip, last_addr;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    n_wr = 0;
    n_skip = 0;
    n_done = 0;
    first_skip = -1;
    last_addr = -1;
  endtask

  // Samples 2ns after the falling edge, clear of stimulus changes
  task automatic monitor();
    exp_t          e;
    logic          stall = 1'b0;
    logic [AW-1:0] st_addr = '0;
    logic [127:0]  st_data = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        if (done) n_done++;
        if (stall) begin
          n_vec++;
          assert ({mem.mem_wr_valid, mem.mem_wr_addr, mem.mem_wr_data}
                  === {1'b1, st_addr, st_data}) else begin
            n_err++;
            $error("FAIL hold observed=%0d/%h expected=1/%h",
                   mem.mem_wr_valid, mem.mem_wr_addr, st_addr);
          end
        end
        if (mem.mem_wr_valid && mem.mem_wr_ready) begin
          n_wr++;
          last_addr = int'(mem.mem_wr_addr);
          while (sb.size() > 0 && sb[0].addr < mem.mem_wr_addr) begin
            if (first_skip < 0) first_skip = int'(sb[0].addr);
            void'(sb.pop_front());
            n_skip++;
          end
          n_vec++;
          assert (sb.size() > 0) else begin
            n_err++;
            $error("FAIL wr_unexpected observed=addr %0d expected=none",
                   mem.mem_wr_addr);
          end
          if (sb.size() > 0) begin
            e = sb.pop_front();
            n_vec++;
            assert ({mem.mem_wr_addr, mem.mem_wr_data}
                    === {e.addr, e.data}) else begin
              n_err++;
              $error("FAIL wr_word observed=%0d/%h expected=%0d/%h",
                     mem.mem_wr_addr, mem.mem_wr_data, e.addr, e.data);
            end
          end
        end
        stall   = mem.mem_wr_valid && !mem.mem_wr_ready;
        st_addr = mem.mem_wr_addr;
        st_data = mem.mem_wr_data;
      end
    end
  endtask

  task automatic do_arm(input int n);
    @(negedge clk);
    num = AW'(n);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic drive(input int a, input bit keep);
    exp_t x;
    di = {$urandom(), $urandom()};
    dq = {$urandom(), $urandom()};
    adc = 1'b1;
    fv = 1'b1;
    if (keep) begin
      x.addr = AW'(a);
      x.data = {di, dq};
      sb.push_back(x);
    end
  endtask

  task automatic idle_in();
    adc = 1'b0;
    fv = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    bit seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    @(negedge clk);
    chk({tag, "_idle_after"}, {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      monitor();
    join_none
    mem.mem_wr_ready = 1'b0;
    clear_stats();
    repeat (3) @(negedge clk);
    n_vec++;
    assert ({busy, done, overflow, mem.mem_wr_valid,
             mem.mem_wr_addr, mem.mem_wr_data} === '0) else begin
      n_err++;
      $error("FAIL reset_outs observed=%b%b%b%b expected=0000",
             busy, done, overflow, mem.mem_wr_valid);
    end
    rst_n = 1'b1;

    // basic capture of 8 words
    clear_stats();
    mem.mem_wr_ready = 1'b1;
    do_arm(8);
    chk("basic_busy", 64'(busy), 64'd1);
    drive(0, 1);
    @(negedge clk);
    chk("basic_lat_t1", 64'(mem.mem_wr_valid), 64'd0);
    drive(1, 1);
    @(negedge clk);
    chk("basic_lat_t2", 64'(mem.mem_wr_valid), 64'd1);
    for (int k = 2; k < 8; k++) begin
      drive(k, 1);
      @(negedge clk);
    end
    idle_in();
    wait_done("basic", 50);
    chk("basic_nwr", 64'(n_wr), 64'd8);
    chk("basic_skip", 64'(n_skip), 64'd0);
    chk("basic_sb", 64'(sb.size()), 64'd0);
    chk("basic_ndone", 64'(n_done), 64'd1);
    chk("basic_ovf", 64'(overflow), 64'd0);

    // back-pressure: 40 words, ready low for the first 20 cycles
    clear_stats();
    mem.mem_wr_ready = 1'b0;
    do_arm(40);
    for (int k = 0; k < 40; k++) begin
      drive(k, 1);
      if (k == 19) mem.mem_wr_ready = 1'b1;
      @(negedge clk);
    end
    idle_in();
    wait_done("bp", 200);
    chk("bp_ovf", 64'(overflow), 64'd1);
    chk("bp_first_skip", 64'(first_skip), 64'd16);
    chk("bp_some_drop", 64'(n_skip > 0), 64'd1);
    chk("bp_total", 64'(n_wr + n_skip), 64'd40);
    chk("bp_last_addr", 64'(last_addr), 64'd39);
    chk("bp_sb", 64'(sb.size()), 64'd0);

    // early end after 10 words, with a wait before the first word
    clear_stats();
    do_arm(100);
    adc = 1'b0;
    repeat (3) @(negedge clk);
    chk("early_wait", {62'd0, busy, done}, 64'd2);
    for (int k = 0; k < 10; k++) begin
      drive(k, 1);
      @(negedge clk);
    end
    idle_in();
    wait_done("early", 50);
    chk("early_nwr", 64'(n_wr), 64'd10);
    chk("early_last", 64'(last_addr), 64'd9);
    chk("early_sb", 64'(sb.size()), 64'd0);
    chk("early_ovf", 64'(overflow), 64'd0);

    // zero length
    clear_stats();
    do_arm(0);
    chk("zero_done", {62'd0, busy, done}, 64'd3);
    @(negedge clk);
    chk("zero_idle", {62'd0, busy, done}, 64'd0);
    repeat (3) @(negedge clk);
    chk("zero_nwr", 64'(n_wr), 64'd0);
    chk("zero_ndone", 64'(n_done), 64'd1);

    // arm while capturing is ignored
    clear_stats();
    do_arm(6);
    for (int k = 0; k < 6; k++) begin
      drive(k, 1);
      if (k == 2) begin
        num = AW'(2);
        arm = 1'b1;
      end
      @(negedge clk);
      arm = 1'b0;
    end
    idle_in();
    wait_done("ign", 50);
    chk("ign_nwr", 64'(n_wr), 64'd6);
    chk("ign_last", 64'(last_addr), 64'd5);
    chk("ign_sb", 64'(sb.size()), 64'd0);

    // reset while draining
    clear_stats();
    mem.mem_wr_ready = 1'b0;
    do_arm(4);
    for (int k = 0; k < 4; k++) begin
      drive(k, 1);
      @(negedge clk);
    end
    idle_in();
    repeat (3) @(negedge clk);
    chk("rst_pre", {62'd0, busy, mem.mem_wr_valid}, 64'd3);
    #3 rst_n = 1'b0;
    #1;
    n_vec++;
    assert ({busy, done, overflow, mem.mem_wr_valid,
             mem.mem_wr_addr, mem.mem_wr_data} === '0) else begin
      n_err++;
      $error("FAIL rst_abort observed=%b%b%b%b expected=0000",
             busy, done, overflow, mem.mem_wr_valid);
    end
    @(negedge clk);
    #3 rst_n = 1'b1;
    sb.delete();
    repeat (4) @(negedge clk);
    chk("rst_no_done", 64'(n_done), 64'd0);
    chk("rst_quiet", {62'd0, busy, mem.mem_wr_valid}, 64'd0);
    clear_stats();
    mem.mem_wr_ready = 1'b1;
    do_arm(3);
    for (int k = 0; k < 3; k++) begin
      drive(k, 1);
      @(negedge clk);
    end
    idle_in();
    wait_done("rearm", 50);
    chk("rearm_nwr", 64'(n_wr), 64'd3);
    chk("rearm_last", 64'(last_addr), 64'd2);
    chk("rearm_sb", 64'(sb.size()), 64'd0);
    chk("rearm_ndone", 64'(n_done), 64'd1);

`ifdef ACQ_CAPTURE_DECIM_EN
    // keep words 0, 3, 6, 9
    clear_stats();
    decim = 4'd2;
    do_arm(4);
    for (int k = 0; k < 12; k++) begin
      drive(k / 3, (k % 3) == 0);
      @(negedge clk);
    end
    idle_in();
    decim = 4'd0;
    wait_done("decim", 50);
    chk("decim_nwr", 64'(n_wr), 64'd4);
    chk("decim_last", 64'(last_addr), 64'd3);
    chk("decim_sb", 64'(sb.size()), 64'd0);
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
